// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundles the load, store, memory-port and completion signals of mem_port_arbiter.
// Latency : n/a (wires only).
// Backpressure: ld_ready/st_ready flow from slave to master. Memory-port and completion outputs have no backpressure.
// Ports   : master = request/memory side (drives loads, stores, flush, mem_rdata);
//           slave  = the arbiter (drives ready, memory-port and completion outputs).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 5
);
  logic              flush;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [ROB_W-1:0]  ld_robNum;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              mem_valid;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [ROB_W-1:0]  resp_robNum;

  modport master (
    output flush, ld_valid, ld_addr, ld_robNum, st_valid, st_addr, st_data, mem_rdata,
    input  ld_ready, st_ready, mem_valid, mem_write, mem_addr, mem_wdata,
           resp_valid, resp_data, resp_robNum
  );

  modport slave (
    input  flush, ld_valid, ld_addr, ld_robNum, st_valid, st_addr, st_data, mem_rdata,
    output ld_ready, st_ready, mem_valid, mem_write, mem_addr, mem_wdata,
           resp_valid, resp_data, resp_robNum
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between loads and an in-order buffer of committed stores,
//           forwarding store data to matching loads.
// Latency : load accept at N -> completion at N+2 (hit or miss). Store pop at N -> write at N+1.
// Backpressure: ld_ready/st_ready drop when the store buffer is full or during reset. ld_ready also drops during flush.
// Ports   : clk, reset (sync, active-high), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ROB_W     = 5,
  parameter int STQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(STQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } stq_ent_t;

  // Store buffer state
  stq_ent_t          stq_q [STQ_DEPTH];
  stq_ent_t          stq_d [STQ_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Stage 1: memory port and pending load
  logic              mem_valid_q, mem_valid_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ROB_W-1:0]  pend_rob_q, pend_rob_d;
  logic              pend_hit_q, pend_hit_d;
  logic [DATA_W-1:0] pend_fwd_q, pend_fwd_d;

  // Stage 2: completion
  logic              resp_vld_q, resp_vld_d;
  logic [ROB_W-1:0]  resp_rob_q, resp_rob_d;
  logic              resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0] resp_fwd_q, resp_fwd_d;

  logic              full;
  logic              ld_fire;
  logic              st_fire;
  logic              pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Ready depends only on state, reset and flush, never on the valids.
  assign full         = (count_q == CNT_W'(STQ_DEPTH));
  assign bus.ld_ready = !full && !reset && !bus.flush;
  assign bus.st_ready = !full && !reset;

  assign ld_fire = bus.ld_valid && bus.ld_ready;
  assign st_fire = bus.st_valid && bus.st_ready;
  // A granted load owns the port; otherwise the oldest store drains.
  assign pop     = !ld_fire && (count_q != '0);

  // Youngest-match forwarding: walk from head (oldest) to tail-1 so later
  // matches overwrite earlier ones, then let the same-cycle store win.
  always_comb begin : fwd_search
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < STQ_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (stq_q[idx].addr == bus.ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = stq_q[idx].data;
      end
    end
    if (st_fire && (bus.st_addr == bus.ld_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.st_data;
    end
  end

  always_comb begin : next_state
    stq_d   = stq_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (st_fire) begin
      stq_d[tail_q] = '{addr: bus.st_addr, data: bus.st_data};
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({st_fire, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    mem_valid_d = pop || (ld_fire && !fwd_hit);
    mem_write_d = pop;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (pop) begin
      mem_addr_d  = stq_q[head_q].addr;
      mem_wdata_d = stq_q[head_q].data;
    end else if (ld_fire && !fwd_hit) begin
      mem_addr_d  = bus.ld_addr;
    end

    // ld_fire is already gated by flush, so a flush-cycle load never enters.
    pend_vld_d = ld_fire;
    pend_rob_d = ld_fire ? bus.ld_robNum : pend_rob_q;
    pend_hit_d = ld_fire ? fwd_hit       : pend_hit_q;
    pend_fwd_d = ld_fire ? fwd_data      : pend_fwd_q;

    // Flush also kills the load sitting in stage 1.
    resp_vld_d = pend_vld_q && !bus.flush;
    resp_rob_d = pend_vld_q ? pend_rob_q : resp_rob_q;
    resp_hit_d = pend_vld_q ? pend_hit_q : resp_hit_q;
    resp_fwd_d = pend_vld_q ? pend_fwd_q : resp_fwd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STQ_DEPTH; i++) begin
        stq_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pend_vld_q  <= 1'b0;
      pend_rob_q  <= '0;
      pend_hit_q  <= 1'b0;
      pend_fwd_q  <= '0;
      resp_vld_q  <= 1'b0;
      resp_rob_q  <= '0;
      resp_hit_q  <= 1'b0;
      resp_fwd_q  <= '0;
    end else begin
      stq_q       <= stq_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pend_vld_q  <= pend_vld_d;
      pend_rob_q  <= pend_rob_d;
      pend_hit_q  <= pend_hit_d;
      pend_fwd_q  <= pend_fwd_d;
      resp_vld_q  <= resp_vld_d;
      resp_rob_q  <= resp_rob_d;
      resp_hit_q  <= resp_hit_d;
      resp_fwd_q  <= resp_fwd_d;
    end
  end

  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.resp_valid  = resp_vld_q;
  assign bus.resp_robNum = resp_rob_q;
  // Read data arrives this cycle for a miss; zero when idle so reset reads as 0.
  assign bus.resp_data   = !resp_vld_q ? '0 : (resp_hit_q ? resp_fwd_q : bus.mem_rdata);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed self-checking bench for mem_port_arbiter with a one-cycle memory model.
// Latency : n/a.
// Backpressure: inputs are driven per cycle; readiness is checked, not waited on.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ROB_W(5)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROB_W(5), .STQ_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory: a write at N is committed at the end of N; a read at N returns data in N+1.
  logic [31:0] mem [256];
  int          wr_cnt = 0;
  always @(posedge clk) begin
    if (bus.mem_valid) begin
      if (bus.mem_write) begin
        mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        wr_cnt = wr_cnt + 1;
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_robNum = '0;
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
  endtask

  task automatic drive_ld(input logic [31:0] a, input logic [4:0] tag);
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = a;
    bus.ld_robNum = tag;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
  endtask

  task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    check_val({tag, "_vld"}, bus.mem_valid, 1);
    check_val({tag, "_wr"},  bus.mem_write, 1);
    check_val({tag, "_adr"}, bus.mem_addr, a);
    check_val({tag, "_dat"}, bus.mem_wdata, d);
  endtask

  task automatic check_resp(input string tag, input logic [4:0] tag_exp, input logic [31:0] d);
    check_val({tag, "_vld"}, bus.resp_valid, 1);
    check_val({tag, "_rob"}, bus.resp_robNum, tag_exp);
    check_val({tag, "_dat"}, bus.resp_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int wr0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;   // 0x100
    mem[8'h20] = 32'h12345678;   // 0x80
    reset = 1'b1;
    idle_inputs();

    // Reset state
    tick(); tick();
    #1;
    check_val("rst_ldrdy", bus.ld_ready, 0);
    check_val("rst_strdy", bus.st_ready, 0);
    check_val("rst_memvld", bus.mem_valid, 0);
    check_val("rst_memwr", bus.mem_write, 0);
    check_val("rst_memadr", bus.mem_addr, 0);
    check_val("rst_respvld", bus.resp_valid, 0);
    check_val("rst_respdat", bus.resp_data, 0);
    tick();
    reset = 1'b0;
    #1;
    check_val("rel_ldrdy", bus.ld_ready, 1);
    check_val("rel_strdy", bus.st_ready, 1);

    // Plain load miss
    tick(); drive_ld(32'h100, 5'd3); #1;
    check_val("t1_ldrdy", bus.ld_ready, 1);
    tick(); idle_inputs(); #1;
    check_val("t1_rd_vld", bus.mem_valid, 1);
    check_val("t1_rd_wr", bus.mem_write, 0);
    check_val("t1_rd_adr", bus.mem_addr, 32'h100);
    check_val("t1_early", bus.resp_valid, 0);
    tick(); #1;
    check_resp("t1_resp", 5'd3, 32'hDEADBEEF);
    tick(); #1;
    check_val("t1_resp_end", bus.resp_valid, 0);

    // Two stores to one address, load forwards the youngest
    tick(); drive_st(32'h200, 32'h11); #1;
    tick(); drive_st(32'h200, 32'h22); #1;           // first store drains here
    tick(); idle_inputs(); drive_ld(32'h200, 5'd4); #1;
    check_val("t2_ldrdy", bus.ld_ready, 1);
    check_write("t2_w1", 32'h200, 32'h11);
    tick(); idle_inputs(); #1;
    check_val("t2_no_rd", bus.mem_valid, 0);
    tick(); #1;
    check_resp("t2_resp", 5'd4, 32'h22);
    check_write("t2_w2", 32'h200, 32'h22);
    tick(); #1;
    check_val("t2_idle", bus.mem_valid, 0);
    check_val("t2_memval", mem[8'h80], 32'h22);

    // Same-cycle store and load forward
    tick(); drive_st(32'h300, 32'h55); drive_ld(32'h300, 5'd7); #1;
    check_val("t3_strdy", bus.st_ready, 1);
    check_val("t3_ldrdy", bus.ld_ready, 1);
    tick(); idle_inputs(); #1;
    check_val("t3_no_rd", bus.mem_valid, 0);
    tick(); #1;
    check_resp("t3_resp", 5'd7, 32'h55);
    check_write("t3_w", 32'h300, 32'h55);
    tick(); #1;

    // Fill the buffer while loads keep the port busy
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_st(32'h10 + 32'(4 * i), 32'(i + 1));
      drive_ld(32'h80, 5'(10 + i));
      #1;
      check_val("t4_ldrdy_pre", bus.ld_ready, 1);
      check_val("t4_strdy_pre", bus.st_ready, 1);
      if (i == 2) check_resp("t4_r10", 5'd10, 32'h12345678);
      if (i == 3) check_resp("t4_r11", 5'd11, 32'h12345678);
    end
    tick(); idle_inputs(); drive_ld(32'h10, 5'd14); #1;
    check_val("t4_ldrdy_full", bus.ld_ready, 0);
    check_val("t4_strdy_full", bus.st_ready, 0);
    check_resp("t4_r12", 5'd12, 32'h12345678);
    tick(); #1;
    check_val("t4_ldrdy_rise", bus.ld_ready, 1);
    check_write("t4_w1", 32'h10, 32'h1);
    check_resp("t4_r13", 5'd13, 32'h12345678);
    tick(); idle_inputs(); #1;
    check_val("t4_rd_vld", bus.mem_valid, 1);
    check_val("t4_rd_wr", bus.mem_write, 0);
    check_val("t4_rd_adr", bus.mem_addr, 32'h10);
    tick(); #1;
    check_resp("t4_r14", 5'd14, 32'h1);
    check_write("t4_w2", 32'h14, 32'h2);
    tick(); #1;
    check_write("t4_w3", 32'h18, 32'h3);
    tick(); #1;
    check_write("t4_w4", 32'h1C, 32'h4);
    tick(); #1;
    check_val("t4_drained", bus.mem_valid, 0);

    // Flush kills the in-flight load, the next one completes
    tick(); drive_ld(32'h100, 5'd5); #1;
    check_val("t5_ldrdy", bus.ld_ready, 1);
    tick(); bus.flush = 1'b1; drive_ld(32'h100, 5'd6); #1;
    check_val("t5_ldrdy_flush", bus.ld_ready, 0);
    tick(); bus.flush = 1'b0; drive_ld(32'h100, 5'd7); #1;
    check_val("t5_killed", bus.resp_valid, 0);
    check_val("t5_ldrdy_after", bus.ld_ready, 1);
    tick(); idle_inputs(); #1;
    check_val("t5_not_acc", bus.resp_valid, 0);
    tick(); #1;
    check_resp("t5_resp", 5'd7, 32'hDEADBEEF);
    tick(); #1;
    check_val("t5_end", bus.resp_valid, 0);

    // Reset with buffered stores and a pending load
    wr0 = wr_cnt;
    tick(); drive_st(32'h20, 32'hA1); drive_ld(32'h100, 5'd1); #1;
    tick(); drive_st(32'h24, 32'hA2); drive_ld(32'h100, 5'd2); #1;
    tick(); drive_st(32'h28, 32'hA3); drive_ld(32'h100, 5'd4); #1;
    tick(); idle_inputs(); reset = 1'b1; #1;
    check_val("t6_ldrdy_rst", bus.ld_ready, 0);
    check_val("t6_strdy_rst", bus.st_ready, 0);
    tick(); reset = 1'b0; #1;
    check_val("t6_memvld", bus.mem_valid, 0);
    check_val("t6_memwr", bus.mem_write, 0);
    check_val("t6_memadr", bus.mem_addr, 0);
    check_val("t6_memwdat", bus.mem_wdata, 0);
    check_val("t6_respvld", bus.resp_valid, 0);
    check_val("t6_respdat", bus.resp_data, 0);
    check_val("t6_resprob", bus.resp_robNum, 0);
    check_val("t6_ldrdy", bus.ld_ready, 1);
    check_val("t6_strdy", bus.st_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check_val("t6_quiet_mem", bus.mem_valid, 0);
      check_val("t6_quiet_resp", bus.resp_valid, 0);
    end
    check_val("t6_no_writes", 64'(wr_cnt), 64'(wr0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
